// File: rtl/pilot_removal.sv
// Strips periodic pilot symbols from a framed AXI-Stream, counts corrupted pilots and
// flags frames whose tlast disagrees with the configured frame length.
module pilot_removal #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    FRAME_LEN     = 64,
  parameter int                    PILOT_SPACING = 8,
  parameter int                    PILOT_OFFSET  = 0,
  parameter logic [DATA_WIDTH-1:0] PILOT_VALUE   = DATA_WIDTH'(32'h0000_0001)
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [15:0]           pilot_err_cnt,
  output logic                  frame_err
);

  localparam int IDX_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int LIDX_W = IDX_W + 1;

  function automatic bit is_pilot_idx(input int i);
    return (i >= PILOT_OFFSET) && (((i - PILOT_OFFSET) % PILOT_SPACING) == 0);
  endfunction

  function automatic logic [FRAME_LEN-1:0] build_pilot_mask();
    logic [FRAME_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < FRAME_LEN; i++) m[i] = is_pilot_idx(i);
    return m;
  endfunction

  // FRAME_LEN acts as an unreachable sentinel when every index is a pilot.
  function automatic int last_data_idx();
    int r;
    r = FRAME_LEN;
    for (int i = 0; i < FRAME_LEN; i++) if (!is_pilot_idx(i)) r = i;
    return r;
  endfunction

  localparam logic [FRAME_LEN-1:0] PILOT_MASK = build_pilot_mask();
  localparam logic [LIDX_W-1:0]    LAST_IDX   = LIDX_W'(last_data_idx());
  localparam logic [IDX_W-1:0]     END_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);

  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  ferr_q, ferr_d;
  logic [15:0]           perr_q, perr_d;
  logic                  accept, pilot, at_end;

  assign s_axis_tready = !ARESET && (!tvalid_q || m_axis_tready);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign pilot         = PILOT_MASK[idx_q];
  assign at_end        = (idx_q == END_IDX);

  always_comb begin
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tvalid_d = tvalid_q;
    idx_d    = idx_q;
    perr_d   = perr_q;
    ferr_d   = 1'b0;
    if (m_axis_tready) tvalid_d = 1'b0;
    if (accept) begin
      if (pilot) begin
        if ((s_axis_tdata != PILOT_VALUE) && (perr_q != 16'hFFFF)) perr_d = perr_q + 16'd1;
      end else begin
        tvalid_d = 1'b1;
        tdata_d  = s_axis_tdata;
        tlast_d  = s_axis_tlast || ({1'b0, idx_q} == LAST_IDX);
      end
      // Early tlast (before the end index) and missing tlast (at it) are both errors.
      ferr_d = s_axis_tlast != at_end;
      idx_d  = (s_axis_tlast || at_end) ? '0 : idx_q + IDX_ONE;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      idx_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      ferr_q   <= 1'b0;
      perr_q   <= '0;
    end else begin
      idx_q    <= idx_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      ferr_q   <= ferr_d;
      perr_q   <= perr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pilot_err_cnt = perr_q;
  assign frame_err     = ferr_q;

endmodule

// File: tb/tb_pilot_removal.sv
// Directed and randomized bench for pilot_removal against a beat-level queue model.
module tb_pilot_removal;
  localparam int          FL  = 16;
  localparam int          SP  = 4;
  localparam int          OFF = 0;
  localparam logic [31:0] PV  = 32'h0000_0001;

  logic        ACLK;
  logic        ARESET;
  logic [31:0] s_tdata, m_tdata;
  logic        s_tvalid, s_tready, s_tlast;
  logic        m_tvalid, m_tready, m_tlast;
  logic [15:0] perr;
  logic        ferr;

  logic [31:0] b_sdata, b_mdata;
  logic        b_svalid, b_sready, b_slast;
  logic        b_mvalid, b_mready, b_mlast;
  logic [15:0] b_perr;
  logic        b_ferr;

  pilot_removal #(.DATA_WIDTH(32), .FRAME_LEN(FL), .PILOT_SPACING(SP),
                  .PILOT_OFFSET(OFF), .PILOT_VALUE(PV)) u_dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
    .s_axis_tlast(s_tlast),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast),
    .pilot_err_cnt(perr), .frame_err(ferr));

  pilot_removal #(.DATA_WIDTH(32), .FRAME_LEN(FL), .PILOT_SPACING(1),
                  .PILOT_OFFSET(0), .PILOT_VALUE(PV)) u_all (
    .ACLK(ACLK), .ARESET(ARESET),
    .s_axis_tdata(b_sdata), .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready),
    .s_axis_tlast(b_slast),
    .m_axis_tdata(b_mdata), .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready),
    .m_axis_tlast(b_mlast),
    .pilot_err_cnt(b_perr), .frame_err(b_ferr));

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // Reference model: queue of expected output beats {tlast, tdata}.
  logic [32:0] expq[$];
  int          m_idx;
  logic [15:0] m_cnt;
  logic        m_ferr;
  int          ldi;
  int          passed, total;
  int          out_seen, tlast_seen, ferr_seen;
  logic [31:0] tlast_data;
  bit          rrand;
  bit          pat[4];
  int          rph;

  function automatic bit mpilot(input int i);
    return (i >= OFF) && (((i - OFF) % SP) == 0);
  endfunction

  function automatic logic next_r();
    logic r;
    if (rrand) r = ($urandom_range(0, 3) != 0);
    else       r = pat[rph % 4];
    rph++;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_stats();
    out_seen = 0; tlast_seen = 0; ferr_seen = 0; tlast_data = '0;
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model, cross the rising edge.
  task automatic step(input logic v, input logic [31:0] d, input logic l, input logic r,
                      output bit acc);
    logic exp_rdy;
    s_tvalid = v; s_tdata = d; s_tlast = l; m_tready = r;
    @(negedge ACLK);
    exp_rdy = (expq.size() == 0) || r;
    chk("s_tready", {63'd0, s_tready}, {63'd0, exp_rdy});
    chk("m_tvalid", {63'd0, m_tvalid}, {63'd0, expq.size() != 0});
    if (expq.size() != 0) begin
      chk("m_tdata", {32'd0, m_tdata}, {32'd0, expq[0][31:0]});
      chk("m_tlast", {63'd0, m_tlast}, {63'd0, expq[0][32]});
    end
    chk("frame_err", {63'd0, ferr}, {63'd0, m_ferr});
    chk("pilot_err_cnt", {48'd0, perr}, {48'd0, m_cnt});
    if (m_tvalid === 1'b1 && r) begin
      out_seen++;
      if (m_tlast === 1'b1) begin tlast_seen++; tlast_data = m_tdata; end
    end
    if (ferr === 1'b1) ferr_seen++;
    acc = v && exp_rdy;
    if (expq.size() != 0 && r) void'(expq.pop_front());
    m_ferr = 1'b0;
    if (acc) begin
      if (mpilot(m_idx)) begin
        if (d !== PV && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      end else begin
        expq.push_back({l || (m_idx == ldi), d});
      end
      m_ferr = (l && m_idx < FL - 1) || (!l && m_idx == FL - 1);
      m_idx  = (l || m_idx == FL - 1) ? 0 : m_idx + 1;
    end
    @(posedge ACLK);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b1, d, l, next_r(), acc);
      n++;
    end while (!acc && n < 64);
    if (!acc) begin
      total++;
      $error("FAIL send_timeout: beat %0h not accepted within %0d cycles", d, n);
    end
  endtask

  task automatic drain();
    bit acc;
    int n;
    n = 0;
    do begin
      step(1'b0, 32'd0, 1'b0, next_r(), acc);
      n++;
    end while ((expq.size() != 0 || n < 2) && n < 64);
  endtask

  // Beats 0..n-1; pilot slots carry PV except those flagged in bad_mask; data slot i carries i.
  task automatic frame(input int n, input int tl_at, input logic [31:0] bad, input int bad_mask);
    logic [31:0] d;
    for (int i = 0; i < n; i++) begin
      if (mpilot(i)) d = bad_mask[i] ? bad : PV;
      else           d = i;
      send(d, i == tl_at);
    end
  endtask

  initial begin
    bit acc;
    int exp_bferr;
    passed = 0; total = 0; rph = 0; rrand = 0;
    pat = '{1'b1, 1'b1, 1'b1, 1'b1};
    m_idx = 0; m_cnt = '0; m_ferr = 1'b0;
    ldi = FL;
    for (int i = 0; i < FL; i++) if (!mpilot(i)) ldi = i;
    s_tvalid = 0; s_tdata = '0; s_tlast = 0; m_tready = 0;
    b_svalid = 0; b_sdata = '0; b_slast = 0; b_mready = 0;
    ARESET = 1'b1;
    #2;
    chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
    chk("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
    chk("rst_pilot_err_cnt", {48'd0, perr}, 64'd0);
    chk("rst_frame_err", {63'd0, ferr}, 64'd0);
    chk("rst_s_tready", {63'd0, s_tready}, 64'd0);
    chk("rst_all_s_tready", {63'd0, b_sready}, 64'd0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;

    // Basic frame, output always ready.
    clear_stats();
    frame(FL, FL - 1, PV, 0);
    drain();
    chk("basic_out_count", out_seen, 12);
    chk("basic_tlast_count", tlast_seen, 1);
    chk("basic_tlast_data", {32'd0, tlast_data}, 64'd15);
    chk("basic_frame_err", ferr_seen, 0);

    // Backpressure 1,0,0,1,...
    clear_stats();
    pat = '{1'b1, 1'b0, 1'b0, 1'b1}; rph = 0;
    frame(FL, FL - 1, PV, 0);
    drain();
    chk("bp_out_count", out_seen, 12);
    chk("bp_tlast_data", {32'd0, tlast_data}, 64'd15);
    pat = '{1'b1, 1'b1, 1'b1, 1'b1};

    // Corrupted pilots at 4 and 12.
    clear_stats();
    frame(FL, FL - 1, 32'h0000_DEAD, 32'h0000_1010);
    drain();
    chk("mismatch_cnt", {48'd0, perr}, 64'd2);
    chk("mismatch_out_count", out_seen, 12);

    // Early tlast on data index 9, then on pilot index 8.
    clear_stats();
    frame(10, 9, PV, 0);
    frame(FL, FL - 1, PV, 0);
    drain();
    chk("early_ferr_count", ferr_seen, 1);
    chk("early_tlast_count", tlast_seen, 2);
    clear_stats();
    frame(9, 8, PV, 0);
    drain();
    chk("early_pilot_ferr", ferr_seen, 1);
    chk("early_pilot_tlast", tlast_seen, 0);

    // Late end: no tlast on beat 15.
    clear_stats();
    frame(FL, -1, PV, 0);
    frame(FL, FL - 1, PV, 0);
    drain();
    chk("late_ferr_count", ferr_seen, 1);
    chk("late_tlast_count", tlast_seen, 2);

    // Randomized traffic.
    rrand = 1;
    for (int k = 0; k < 800; k++) begin
      logic [31:0] d;
      logic        l;
      if ($urandom_range(0, 4) == 0) step(1'b0, 32'd0, 1'b0, next_r(), acc);
      else begin
        if (mpilot(m_idx)) d = ($urandom_range(0, 3) == 0) ? $urandom : PV;
        else               d = $urandom;
        if (m_idx == FL - 1) l = ($urandom_range(0, 7) != 0);
        else                 l = ($urandom_range(0, 23) == 0);
        send(d, l);
      end
    end
    drain();
    rrand = 0;

    // Reset mid-frame with an output beat held.
    m_cnt = m_cnt; // model keeps its count until reset
    frame(6, -1, 32'h0000_BEEF, 32'h0000_0010);
    chk("held_before_reset", {63'd0, m_tvalid}, 64'd1);
    m_tready = 1'b0; s_tvalid = 1'b1; s_tdata = 32'd6; s_tlast = 1'b0;
    ARESET = 1'b1;
    #1;
    chk("midrst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
    chk("midrst_m_tdata", {32'd0, m_tdata}, 64'd0);
    chk("midrst_m_tlast", {63'd0, m_tlast}, 64'd0);
    chk("midrst_cnt", {48'd0, perr}, 64'd0);
    chk("midrst_s_tready", {63'd0, s_tready}, 64'd0);
    expq.delete(); m_idx = 0; m_cnt = '0; m_ferr = 1'b0;
    @(posedge ACLK); #1;
    s_tvalid = 1'b0;
    ARESET = 1'b0;
    clear_stats();
    frame(FL, FL - 1, PV, 0);
    drain();
    chk("postrst_out_count", out_seen, 12);
    chk("postrst_tlast_data", {32'd0, tlast_data}, 64'd15);
    chk("postrst_ferr", ferr_seen, 0);

    // All-pilot instance: never outputs, error counter saturates.
    b_svalid = 1'b1; b_sdata = 32'h0000_DEAD; b_slast = 1'b0;
    exp_bferr = 0; ferr_seen = 0;
    for (int i = 0; i < 65540; i++) begin
      @(negedge ACLK);
      if (i == 0)     chk("sat_start", {48'd0, b_perr}, 64'd0);
      if (i == 65534) chk("sat_fffe", {48'd0, b_perr}, 64'h0000_FFFE);
      if (i == 65535) chk("sat_ffff", {48'd0, b_perr}, 64'h0000_FFFF);
      if (b_mvalid !== 1'b0) chk("allpilot_m_tvalid", {63'd0, b_mvalid}, 64'd0);
      if (i > 0 && ((i - 1) % FL) == FL - 1) exp_bferr++;
      if (b_ferr === 1'b1) ferr_seen++;
      b_mready = $urandom_range(0, 1);
      @(posedge ACLK); #1;
    end
    b_svalid = 1'b0;
    @(negedge ACLK);
    chk("sat_hold", {48'd0, b_perr}, 64'h0000_FFFF);
    chk("allpilot_tvalid_end", {63'd0, b_mvalid}, 64'd0);
    chk("allpilot_tdata", {32'd0, b_mdata}, 64'd0);
    chk("allpilot_tlast", {63'd0, b_mlast}, 64'd0);
    chk("allpilot_ferr_count", ferr_seen, exp_bferr);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/pilot_removal.md
PILOT_REMOVAL -- requirements
Module: pilot_removal

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: symbol width in bits.
REQ-002 SHALL have parameter FRAME_LEN, default 64: input beats per frame, pilots included; legal range 2..4096.
REQ-003 SHALL have parameter PILOT_SPACING, default 8: pilot period in beats; legal range 1..FRAME_LEN.
REQ-004 SHALL have parameter PILOT_OFFSET, default 0: index of the first pilot within the frame; legal range 0..PILOT_SPACING-1.
REQ-005 SHALL have parameter PILOT_VALUE, default 32'h0000_0001: expected pilot symbol.
REQ-006 ACLK  in  1  sole clock; all logic on its rising edge.
REQ-007 ARESET  in  1  asynchronous, active-high reset.
REQ-008 s_axis_tdata  in  DATA_WIDTH  input symbol.
REQ-009 s_axis_tvalid  in  1  input valid.
REQ-010 s_axis_tready  out  1  input ready.
REQ-011 s_axis_tlast  in  1  end of input frame.
REQ-012 m_axis_tdata  out  DATA_WIDTH  data symbol, pilots removed.
REQ-013 m_axis_tvalid  out  1  output valid.
REQ-014 m_axis_tready  in  1  output ready.
REQ-015 m_axis_tlast  out  1  last data symbol of a frame.
REQ-016 pilot_err_cnt  out  16  saturating count of mismatched pilots.
REQ-017 frame_err  out  1  one-cycle pulse on a tlast/length mismatch.

Function
REQ-018 Position rule: beat index i (0..FRAME_LEN-1) SHALL be a pilot when i >= PILOT_OFFSET and (i-PILOT_OFFSET) mod PILOT_SPACING == 0; every other index is data.
REQ-019 Index counter: SHALL advance by 1 on each accepted input beat (s_axis_tvalid & s_axis_tready).
- Counter SHALL return to 0 after index FRAME_LEN-1, or on any accepted beat with s_axis_tlast=1.
REQ-020 Output stage: SHALL be a single output register.
- s_axis_tready = !m_axis_tvalid | m_axis_tready.
- Latency from accepted data beat to m_axis_tvalid: exactly 1 cycle.
- Full throughput with m_axis_tready held high.
REQ-021 Data beats: an accepted data beat SHALL load m_axis_tdata and set m_axis_tvalid=1.
REQ-022 Pilot beats: an accepted pilot beat SHALL NOT load the output register.
- A held output beat still completes on m_axis_tready in the same cycle.
REQ-023 Output valid hold: m_axis_tvalid, tdata and tlast SHALL remain stable until m_axis_tready=1.
- m_axis_tvalid SHALL clear after the handshake unless a new data beat is accepted in the same cycle.
REQ-024 Output tlast: m_axis_tlast SHALL be 1 on a data beat whose index equals LAST_DATA_IDX, or whose input s_axis_tlast=1.
- LAST_DATA_IDX = highest data index in the frame, computed at elaboration.
REQ-025 Pilot check: a pilot beat with tdata != PILOT_VALUE SHALL increment pilot_err_cnt by 1.
- Saturates at 16'hFFFF, never wraps.
REQ-026 Early end: accepted s_axis_tlast=1 at index < FRAME_LEN-1 SHALL pulse frame_err for 1 cycle.
- Frame index restarts at 0.
- If that beat is a pilot, no m_axis_tlast is emitted for the truncated frame.
REQ-027 Late end: accepted beat at index FRAME_LEN-1 with s_axis_tlast=0 SHALL pulse frame_err for 1 cycle.
- Counter wraps to 0 and processing continues.
REQ-028 Simultaneous output handshake and new data beat in one cycle SHALL replace the register contents with no bubble.
REQ-029 If every index is a pilot (PILOT_SPACING=1, PILOT_OFFSET=0), m_axis_tvalid SHALL stay 0 permanently.
REQ-030 No combinational path SHALL exist from s_axis_tvalid/tdata to any m_axis output.

Reset
REQ-031 ARESET=1 SHALL asynchronously force:
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0
- index counter=0, pilot_err_cnt=0, frame_err=0
REQ-032 During reset, s_axis_tready SHALL be 0.
REQ-033 Reset mid-frame SHALL discard the held output beat and the partial frame.
- The first accepted beat after release is index 0.
REQ-034 After deassertion, s_axis_tready SHALL be 1 in the first cycle.

Verification
REQ-035 Basic frame (FRAME_LEN=16, PILOT_SPACING=4, PILOT_OFFSET=0, m_axis_tready=1): input 0x1,1,2,3,0x1,5,6,7,0x1,9,10,11,0x1,13,14,15, tlast on 15.
- Output 1,2,3,5,6,7,9,10,11,13,14,15; tlast only on 15.
- pilot_err_cnt=0; frame_err never pulses.
REQ-036 Backpressure: same frame with m_axis_tready toggling 1,0,0,1,...
- Identical output sequence, no loss or duplication.
- tdata stable while stalled.
REQ-037 Pilot mismatch: pilots at indices 4 and 12 set to 0xDEAD.
- pilot_err_cnt=2; data output unchanged.
- Forcing 0x10000 mismatches yields pilot_err_cnt=16'hFFFF.
REQ-038 Early tlast: s_axis_tlast at index 9.
- Output tlast on data 9; frame_err pulses once.
- Next beat is treated as index 0 (pilot, dropped).
REQ-039 Late tlast: 16 beats without tlast.
- frame_err pulses on beat 15; output tlast still on data 15.
REQ-040 Reset at index 6 with an output beat held: outputs clear immediately.
- A following clean frame gives the REQ-035 result.
